// File: rtl/cas_pkg.sv
// cas_pkg: shared definitions for the cassette playback engine.
//   - cas_state_t : playback state machine encoding
//   - CAS_HALF0/1 : default half-period lengths (clk cycles at 42.954 MHz)
//   - cas_max     : helper used to size the half-period counter
package cas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HIGH  = 3'd3,
        ST_LOW   = 3'd4,
        ST_DONE  = 3'd5
    } cas_state_t;

    // 1200 Hz (0 bit) and 2400 Hz (1 bit) half periods.
    localparam int CAS_HALF0 = 17898;
    localparam int CAS_HALF1 = 8949;

    function automatic int cas_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dpram.sv
// dpram: simple dual-port RAM, single clock.
//   clock     : RAM clock
//   address_a : read address, q_a valid one clock later
//   q_a       : registered read data
//   address_b : write address
//   data_b    : write data
//   wren_b    : write enable; the write lands on the next clock edge
// Contents are not reset.
module dpram #(
    parameter int addr_width_g = 8,
    parameter int data_width_g = 8
) (
    input  logic                    clock,
    input  logic [addr_width_g-1:0] address_a,
    output logic [data_width_g-1:0] q_a,
    input  logic [addr_width_g-1:0] address_b,
    input  logic [data_width_g-1:0] data_b,
    input  logic                    wren_b
);

    logic [data_width_g-1:0] mem [0:(2**addr_width_g)-1];

    // Registered read on port a, write on port b.
    always_ff @(posedge clock) begin
        q_a <= mem[address_a];
        if (wren_b) begin
            mem[address_b] <= data_b;
        end
    end

endmodule

// File: rtl/cas_player.sv
// cas_player: captures a .cas image from the ioctl download channel and,
// while the cassette motor relay is on, replays it as a Tandy/Dragon FSK
// square wave (LSB first, one HIGH half + one LOW half per bit).
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   load_sel            : current download targets the tape
//   ioctl_download/wr   : download in progress / byte write strobe
//   ioctl_addr/data     : byte address / byte data
//   motor               : cassette relay from the core
//   rewind              : one-clk pulse, restart from byte 0
//   casdout             : FSK audio bit to the core
//   playing             : waveform currently advancing
//   done                : whole image has been played
//   pos                 : index of the byte being played
module cas_player
    import cas_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int HALF0  = CAS_HALF0,
    parameter int HALF1  = CAS_HALF1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_sel,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              motor,
    input  logic              rewind,
    output logic              casdout,
    output logic              playing,
    output logic              done,
    output logic [ADDR_W-1:0] pos
);

    localparam int CNT_W = $clog2(cas_max(HALF0, HALF1) + 1);
    localparam logic [CNT_W-1:0] H0_M1 = CNT_W'(HALF0 - 1);
    localparam logic [CNT_W-1:0] H1_M1 = CNT_W'(HALF1 - 1);

    cas_state_t        state_r;
    logic              dl_prev_r;
    logic [ADDR_W:0]   len_r;
    logic              loaded_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        shift_r;
    logic [7:0]        next_byte_r;
    logic              pf_r;

    logic              dl_s;
    logic              dl_start_s;
    logic              dl_end_s;
    logic              wr_s;
    logic [ADDR_W:0]   wr_len_s;
    logic [ADDR_W:0]   pos_inc_s;
    logic              last_byte_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [7:0]        rd_data_s;
    logic [CNT_W-1:0]  half_m1_s;

    assign dl_s        = ioctl_download & load_sel;
    assign dl_start_s  = dl_s & ~dl_prev_r;
    assign dl_end_s    = ~dl_s & dl_prev_r;
    assign wr_s        = ioctl_wr & load_sel;
    assign wr_len_s    = {1'b0, ioctl_addr} + (ADDR_W+1)'(1);
    assign pos_inc_s   = {1'b0, pos_r_view()} + (ADDR_W+1)'(1);
    assign last_byte_s = (pos_inc_s == len_r);
    assign half_m1_s   = shift_r[0] ? H1_M1 : H0_M1;

    assign playing = motor & ((state_r == ST_HIGH) | (state_r == ST_LOW));

    function automatic logic [ADDR_W-1:0] pos_r_view();
        return pos;
    endfunction

    // Read address: current byte while fetching, otherwise the prefetch target.
    always_comb begin
        rd_addr_s = pos_inc_s[ADDR_W-1:0];
        if (state_r == ST_FETCH) begin
            rd_addr_s = pos;
        end else begin
            rd_addr_s = pos_inc_s[ADDR_W-1:0];
        end
    end

    dpram #(
        .addr_width_g (ADDR_W),
        .data_width_g (8)
    ) u_buf (
        .clock     (clk),
        .address_a (rd_addr_s),
        .q_a       (rd_data_s),
        .address_b (ioctl_addr),
        .data_b    (ioctl_data),
        .wren_b    (wr_s)
    );

    // Download bookkeeping: image length and loaded flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dl_prev_r <= 1'b0;
            len_r     <= '0;
            loaded_r  <= 1'b0;
        end else begin
            dl_prev_r <= dl_s;
            if (wr_s && (dl_start_s || (wr_len_s > len_r))) begin
                len_r <= wr_len_s;
            end else if (dl_start_s) begin
                len_r <= '0;
            end else begin
                len_r <= len_r;
            end
            if (dl_start_s) begin
                loaded_r <= 1'b0;
            end else if (dl_end_s) begin
                loaded_r <= (len_r != '0);
            end else begin
                loaded_r <= loaded_r;
            end
        end
    end

    // Playback state machine with registered casdout/done/pos.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            pos         <= '0;
            done        <= 1'b0;
            casdout     <= 1'b0;
            cnt_r       <= '0;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            next_byte_r <= 8'h00;
            pf_r        <= 1'b0;
        end else begin
            // Prefetched byte arrives one clk after the read is issued.
            pf_r <= 1'b0;
            if (pf_r) begin
                next_byte_r <= rd_data_s;
            end
            if (dl_start_s || (rewind && !dl_s)) begin
                state_r <= ST_IDLE;
                pos     <= '0;
                done    <= 1'b0;
                casdout <= 1'b0;
                cnt_r   <= '0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        casdout <= 1'b0;
                        if (loaded_r && motor && !done && !dl_s) begin
                            state_r <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        state_r <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        shift_r   <= rd_data_s;
                        bit_idx_r <= 3'd0;
                        cnt_r     <= '0;
                        casdout   <= 1'b1;
                        state_r   <= ST_HIGH;
                    end
                    ST_HIGH: begin
                        // motor low freezes the counter and holds casdout
                        if (motor) begin
                            if (cnt_r == half_m1_s) begin
                                cnt_r   <= '0;
                                casdout <= 1'b0;
                                state_r <= ST_LOW;
                                if ((bit_idx_r == 3'd7) && !last_byte_s) begin
                                    pf_r <= 1'b1;
                                end
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    ST_LOW: begin
                        if (motor) begin
                            if (cnt_r == half_m1_s) begin
                                cnt_r <= '0;
                                if (bit_idx_r == 3'd7) begin
                                    if (last_byte_s) begin
                                        done    <= 1'b1;
                                        state_r <= ST_DONE;
                                    end else begin
                                        // seamless handoff; covers very short halves too
                                        pos       <= pos_inc_s[ADDR_W-1:0];
                                        shift_r   <= pf_r ? rd_data_s : next_byte_r;
                                        bit_idx_r <= 3'd0;
                                        casdout   <= 1'b1;
                                        state_r   <= ST_HIGH;
                                    end
                                end else begin
                                    bit_idx_r <= bit_idx_r + 3'd1;
                                    shift_r   <= {1'b0, shift_r[7:1]};
                                    casdout   <= 1'b1;
                                    state_r   <= ST_HIGH;
                                end
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        casdout <= 1'b0;
                        done    <= 1'b1;
                    end
                    default: begin
                        casdout <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cas_player.sv
// tb_cas_player: directed self-checking bench for cas_player with
// HALF0=8 and HALF1=4. Outputs are sampled on the falling clock edge.
module tb_cas_player;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_sel = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [15:0] ioctl_addr = 16'h0000;
    logic [7:0]  ioctl_data = 8'h00;
    logic        motor = 1'b0;
    logic        rewind = 1'b0;
    logic        casdout;
    logic        playing;
    logic        done;
    logic [15:0] pos;

    int vectors = 0;
    int miscompares = 0;

    cas_player #(.ADDR_W(16), .HALF0(8), .HALF1(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .load_sel       (load_sel),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .motor          (motor),
        .rewind         (rewind),
        .casdout        (casdout),
        .playing        (playing),
        .done           (done),
        .pos            (pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Length of the current run of casdout==val (stops early if done rises).
    task automatic meas(input logic val, output int n);
        n = 0;
        while (casdout === val && done === 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Clocks until casdout first goes high.
    task automatic wait_rise(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (casdout !== 1'b1 && n < 50);
    endtask

    task automatic play_byte(input logic [7:0] b, input string tag);
        int n;
        for (int i = 0; i < 8; i++) begin
            meas(1'b1, n);
            check($sformatf("%s bit%0d high", tag, i), n, b[i] ? 32'd4 : 32'd8);
            meas(1'b0, n);
            check($sformatf("%s bit%0d low", tag, i), n, b[i] ? 32'd4 : 32'd8);
        end
    endtask

    task automatic dl_begin();
        load_sel = 1'b1;
        ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic dl_write(input logic [15:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1;
        ioctl_addr = a;
        ioctl_data = d;
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic pulse_rewind();
        rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
    endtask

    initial begin
        int n;
        int highs;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst casdout", casdout, 1'b0);
        check("rst playing", playing, 1'b0);
        check("rst done", done, 1'b0);
        check("rst pos", pos, 16'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single byte 0x55
        dl_begin();
        dl_write(16'd0, 8'h55);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk);
        check("idle no motor casdout", casdout, 1'b0);
        motor = 1'b1;
        wait_rise(n);
        check("single latency", n, 32'd3);
        play_byte(8'h55, "single");
        check("single done", done, 1'b1);
        check("single pos", pos, 16'd0);
        check("single casdout", casdout, 1'b0);
        repeat (5) @(negedge clk);
        check("single done hold", done, 1'b1);
        check("single casdout hold", casdout, 1'b0);

        // Two bytes 0x00,0xFF with a motor pause in the first HIGH half
        motor = 1'b0;
        dl_begin();
        check("dl clears done", done, 1'b0);
        dl_write(16'd0, 8'h00);
        dl_write(16'd1, 8'hFF);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk);
        motor = 1'b1;
        wait_rise(n);
        check("multi latency", n, 32'd3);
        n = 0;
        while (casdout === 1'b1 && n < 200) begin
            n++;
            if (n == 3) motor = 1'b0;
            if (n == 10) begin
                check("pause playing", playing, 1'b0);
                check("pause casdout", casdout, 1'b1);
            end
            if (n == 23) motor = 1'b1;
            @(negedge clk);
        end
        check("pause high total", n, 32'd28);
        meas(1'b0, n);
        check("multi b0 bit0 low", n, 32'd8);
        for (int i = 1; i < 8; i++) begin
            meas(1'b1, n);
            check($sformatf("multi b0 bit%0d high", i), n, 32'd8);
            meas(1'b0, n);
            check($sformatf("multi b0 bit%0d low", i), n, 32'd8);
        end
        check("multi pos1", pos, 16'd1);
        play_byte(8'hFF, "multi b1");
        check("multi done", done, 1'b1);
        check("multi end pos", pos, 16'd1);

        // Rewind from DONE, then rewind mid-play at pos 1
        pulse_rewind();
        check("rew pos", pos, 16'd0);
        check("rew done", done, 1'b0);
        check("rew casdout", casdout, 1'b0);
        wait_rise(n);
        check("rew latency", n, 32'd3);
        play_byte(8'h00, "rew b0");
        check("rew pos1", pos, 16'd1);
        meas(1'b1, n);
        check("rew b1 high", n, 32'd4);
        meas(1'b0, n);
        check("rew b1 low", n, 32'd4);
        pulse_rewind();
        check("rew mid casdout", casdout, 1'b0);
        check("rew mid playing", playing, 1'b0);
        check("rew mid pos", pos, 16'd0);
        wait_rise(n);
        check("rew mid latency", n, 32'd3);
        meas(1'b1, n);
        check("rew replay high", n, 32'd8);

        // Reload mid-play: addresses written out of order, len must be 3
        dl_begin();
        check("reload casdout", casdout, 1'b0);
        check("reload playing", playing, 1'b0);
        check("reload pos", pos, 16'd0);
        dl_write(16'd2, 8'h80);
        dl_write(16'd0, 8'h01);
        dl_write(16'd1, 8'hFE);
        ioctl_download = 1'b0;
        wait_rise(n);
        check("reload latency", n, 32'd4);
        play_byte(8'h01, "reload b0");
        check("reload pos1", pos, 16'd1);
        play_byte(8'hFE, "reload b1");
        check("reload pos2", pos, 16'd2);
        play_byte(8'h80, "reload b2");
        check("reload done", done, 1'b1);
        check("reload end pos", pos, 16'd2);

        // Reset during a LOW half
        pulse_rewind();
        wait_rise(n);
        check("pre-reset latency", n, 32'd3);
        meas(1'b1, n);
        check("pre-reset high", n, 32'd4);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("reset casdout", casdout, 1'b0);
        check("reset playing", playing, 1'b0);
        check("reset done", done, 1'b0);
        check("reset pos", pos, 16'd0);
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (casdout === 1'b1) highs++;
        end
        check("reset no playback", highs, 32'd0);
        dl_begin();
        dl_write(16'd0, 8'hAA);
        ioctl_download = 1'b0;
        wait_rise(n);
        check("post-reset latency", n, 32'd4);
        play_byte(8'hAA, "post-reset");
        check("post-reset done", done, 1'b1);
        check("post-reset pos", pos, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
